// File: rtl/mem_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a register demux.
// One transaction at a time; reads wait a fixed RD_LATENCY for data.
module mem_reg_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [1:0]                  req,
  input  logic [1:0]                  we,
  input  logic [2*ADDR_WIDTH-1:0]     addr,
  input  logic [2*DATA_WIDTH-1:0]     wdata,
  input  logic [2*DATA_WIDTH/8-1:0]   wstrb,
  output logic [1:0]                  ack,
  output logic [2*DATA_WIDTH-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0]       mem_wrAddr,
  output logic [DATA_WIDTH-1:0]       mem_wrdin,
  output logic [DATA_WIDTH/8-1:0]     mem_wrByteStrobe,
  output logic [ADDR_WIDTH-1:0]       mem_rdAddr,
  output logic                        mem_rdStrobe,
  input  logic [DATA_WIDTH-1:0]       mem_rddout,
  output logic                        busy,
  output logic                        grant_id
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDWAIT,
    S_ACK
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic                      r_gid;
  logic                      r_last;
  logic [2:0]                r_cnt;
  logic [ADDR_WIDTH-1:0]     r_wraddr;
  logic [DATA_WIDTH-1:0]     r_wrdin;
  logic [SW-1:0]             r_wstrb;
  logic [ADDR_WIDTH-1:0]     r_rdaddr;
  logic [2*DATA_WIDTH-1:0]   r_rdata;

  logic                      w_win;
  logic                      w_we;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [SW-1:0]             w_wstrb;
  logic                      w_start;
  logic                      w_cap;
  logic [1:0]                w_ack;

  // Tie goes to whoever was not served last
  always_comb begin
    w_win = req[1];
    if (req == 2'b11) begin
      w_win = ~r_last;
    end
  end

  assign w_we    = w_win ? we[1] : we[0];
  assign w_addr  = w_win ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                         : addr[ADDR_WIDTH-1:0];
  assign w_wdata = w_win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                         : wdata[DATA_WIDTH-1:0];
  assign w_wstrb = w_win ? wstrb[2*SW-1:SW]
                         : wstrb[SW-1:0];

  assign w_start = (r_state == S_IDLE) && (|req);
  assign w_cap   = (r_state == S_RDWAIT) && (r_cnt <= 3'd1);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_next = w_we ? S_WR : S_RD;
        end
      end
      S_WR: begin
        w_next = S_ACK;
      end
      S_RD: begin
        w_next = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (w_cap) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        w_ack  = r_gid ? 2'b10 : 2'b01;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_gid    <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= 3'd0;
      r_wraddr <= '0;
      r_wrdin  <= '0;
      r_wstrb  <= '0;
      r_rdaddr <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_start) begin
        r_gid <= w_win;
        if (w_we) begin
          r_wraddr <= w_addr;
          r_wrdin  <= w_wdata;
          r_wstrb  <= w_wstrb;
        end else begin
          r_rdaddr <= w_addr;
        end
      end
      if (r_state == S_RD) begin
        r_cnt <= 3'(RD_LATENCY);
      end else if (r_state == S_RDWAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_cap) begin
        if (r_gid) begin
          r_rdata[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rddout;
        end else begin
          r_rdata[DATA_WIDTH-1:0] <= mem_rddout;
        end
      end
      if (r_state == S_ACK) begin
        r_last <= r_gid;
      end
    end
  end

  assign ack              = w_ack;
  assign rdata            = r_rdata;
  assign mem_wrAddr       = r_wraddr;
  assign mem_wrdin        = r_wrdin;
  assign mem_wrByteStrobe = (r_state == S_WR) ? r_wstrb : '0;
  assign mem_rdAddr       = r_rdaddr;
  assign mem_rdStrobe     = (r_state == S_RD);
  assign busy             = (r_state != S_IDLE);
  assign grant_id         = r_gid;

endmodule

// File: tb/tb_mem_reg_arbiter.sv
// Directed bench for mem_reg_arbiter with RD_LATENCY=2.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_mem_reg_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [7:0]      wstrb;
  logic [1:0]      ack;
  logic [2*DW-1:0] rdata;
  logic [AW-1:0]   mem_wrAddr;
  logic [DW-1:0]   mem_wrdin;
  logic [3:0]      mem_wrByteStrobe;
  logic [AW-1:0]   mem_rdAddr;
  logic            mem_rdStrobe;
  logic [DW-1:0]   mem_rddout;
  logic            busy;
  logic            grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_reg_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT)
  ) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .req              (req),
    .we               (we),
    .addr             (addr),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .ack              (ack),
    .rdata            (rdata),
    .mem_wrAddr       (mem_wrAddr),
    .mem_wrdin        (mem_wrdin),
    .mem_wrByteStrobe (mem_wrByteStrobe),
    .mem_rdAddr       (mem_rdAddr),
    .mem_rdStrobe     (mem_rdStrobe),
    .mem_rddout       (mem_rddout),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic g;
    rst_n = 1'b0; req = '0; we = '0; addr = '0;
    wdata = '0; wstrb = '0; mem_rddout = '0;
    cyc; cyc;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wraddr", mem_wrAddr, 0);
    chk("rst_wrdin", mem_wrdin, 0);
    chk("rst_wstrb", mem_wrByteStrobe, 0);
    chk("rst_rdaddr", mem_rdAddr, 0);
    chk("rst_rdstb", mem_rdStrobe, 0);
    chk("rst_gid", grant_id, 0);
    rst_n = 1'b1;
    cyc;

    // requester 0 write, req dropped right after grant
    req = 2'b01; we = 2'b01; addr = {9'd0, 9'd5};
    wdata = {32'h0, 32'hDEADBEEF}; wstrb = 8'h0F;
    cyc;
    req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
    chk("A_wstrb", mem_wrByteStrobe, 4'hF);
    chk("A_wraddr", mem_wrAddr, 5);
    chk("A_wrdin", mem_wrdin, 32'hDEADBEEF);
    chk("A_ack_t1", ack, 0);
    chk("A_busy", busy, 1);
    chk("A_gid", grant_id, 0);
    chk("A_rdstb", mem_rdStrobe, 0);
    cyc;
    chk("A_ack_t2", ack, 2'b01);
    chk("A_wstrb_t2", mem_wrByteStrobe, 0);
    chk("A_wraddr_hold", mem_wrAddr, 5);
    cyc;
    chk("A_ack_t3", ack, 0);
    chk("A_busy_t3", busy, 0);

    // requester 1 read, data valid only at T+3
    req = 2'b10; we = 2'b00; addr = {9'd3, 9'd0};
    cyc;
    req = '0; addr = '0;
    chk("B_rdstb", mem_rdStrobe, 1);
    chk("B_rdaddr", mem_rdAddr, 3);
    chk("B_gid", grant_id, 1);
    chk("B_ack_t1", ack, 0);
    cyc;
    chk("B_rdstb_t2", mem_rdStrobe, 0);
    chk("B_ack_t2", ack, 0);
    chk("B_busy_t2", busy, 1);
    cyc;
    chk("B_ack_t3", ack, 0);
    mem_rddout = 32'h12345678;
    cyc;
    mem_rddout = '0;
    chk("B_ack_t4", ack, 2'b10);
    chk("B_rdata", rdata, {32'h12345678, 32'h0});
    cyc;
    chk("B_ack_t5", ack, 0);
    chk("B_rdata_hold", rdata, {32'h12345678, 32'h0});
    chk("B_busy_t5", busy, 0);

    rst_n = 1'b0;
    cyc;
    chk("R2_rdata", rdata, 0);
    rst_n = 1'b1;
    cyc;

    // both requesters hold req: grants alternate 0,1,0,1
    req = 2'b11; we = 2'b11; addr = {9'd7, 9'd6};
    wdata = {32'h11111111, 32'h22222222}; wstrb = {4'hC, 4'h3};
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1);
      cyc;
      chk("C_gid", grant_id, g);
      chk("C_wraddr", mem_wrAddr, g ? 9'd7 : 9'd6);
      chk("C_wstrb", mem_wrByteStrobe, g ? 4'hC : 4'h3);
      cyc;
      chk("C_ack", ack, g ? 2'b10 : 2'b01);
      cyc;
      chk("C_idle", busy, 0);
    end
    req = '0; we = '0;

    // requester 0 read to populate rdata[0]
    req = 2'b01; we = 2'b00; addr = {9'd0, 9'd9};
    cyc;
    req = '0; addr = '0;
    chk("E_rdaddr", mem_rdAddr, 9);
    chk("E_gid", grant_id, 0);
    chk("E_wraddr_hold", mem_wrAddr, 7);
    cyc;
    chk("E_ack_t2", ack, 0);
    cyc;
    chk("E_ack_t3", ack, 0);
    mem_rddout = 32'hA5A50F0F;
    cyc;
    mem_rddout = '0;
    chk("E_ack_t4", ack, 2'b01);
    chk("E_rdata", rdata, {32'h0, 32'hA5A50F0F});
    cyc;

    // zero-strobe write completes and leaves rdata alone
    req = 2'b01; we = 2'b01; addr = {9'd0, 9'h1FF};
    wdata = {32'h0, 32'hCAFEF00D}; wstrb = 8'h00;
    cyc;
    req = '0; we = '0;
    chk("D_wstrb_t1", mem_wrByteStrobe, 0);
    chk("D_wrdin", mem_wrdin, 32'hCAFEF00D);
    chk("D_wraddr", mem_wrAddr, 9'h1FF);
    chk("D_busy", busy, 1);
    cyc;
    chk("D_wstrb_t2", mem_wrByteStrobe, 0);
    chk("D_ack_t2", ack, 2'b01);
    cyc;
    chk("D_ack_t3", ack, 0);
    chk("D_rdata", rdata, {32'h0, 32'hA5A50F0F});

    // reset during RDWAIT aborts the read
    req = 2'b10; we = 2'b00; addr = {9'd4, 9'd0};
    cyc;
    req = '0;
    chk("F_rdstb", mem_rdStrobe, 1);
    chk("F_gid", grant_id, 1);
    cyc;
    mem_rddout = 32'hFFFFFFFF;
    rst_n = 1'b0;
    cyc;
    chk("F_ack", ack, 0);
    chk("F_busy", busy, 0);
    chk("F_rdata", rdata, 0);
    chk("F_rdaddr", mem_rdAddr, 0);
    chk("F_wraddr", mem_wrAddr, 0);
    chk("F_wrdin", mem_wrdin, 0);
    chk("F_gid_rst", grant_id, 0);
    chk("F_rdstb_rst", mem_rdStrobe, 0);
    cyc;
    chk("F_ack_rst2", ack, 0);
    rst_n = 1'b1; mem_rddout = '0;
    req = 2'b11; we = 2'b11; addr = {9'd2, 9'd1}; wstrb = 8'hFF;
    cyc;
    chk("F_first_gid", grant_id, 0);
    chk("F_first_addr", mem_wrAddr, 1);
    cyc;
    chk("F_first_ack", ack, 2'b01);
    req = '0; we = '0;
    cyc;
    chk("F_end_ack", ack, 0);
    chk("F_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_reg_arbiter.md
MEM_REG_ARBITER -- requirements
Module: mem_reg_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning register word-address width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal 1..4, meaning cycles from mem_rdStrobe to valid mem_rddout.
REQ-004 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port S_AXI_ARESETN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  2  per-requester access request (bit 0 = AXI slave side, bit 1 = local sequencer).
REQ-007 SHALL have port we  input  2  per-requester write (1) / read (0).
REQ-008 SHALL have port addr  input  2*ADDR_WIDTH  packed per-requester word address.
REQ-009 SHALL have port wdata  input  2*DATA_WIDTH  packed per-requester write data.
REQ-010 SHALL have port wstrb  input  2*DATA_WIDTH/8  packed per-requester byte strobes.
REQ-011 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port rdata  output  2*DATA_WIDTH  packed per-requester read data.
REQ-013 SHALL have port mem_wrAddr  output  ADDR_WIDTH  write address to register demux.
REQ-014 SHALL have port mem_wrdin  output  DATA_WIDTH  write data to register demux.
REQ-015 SHALL have port mem_wrByteStrobe  output  DATA_WIDTH/8  write byte strobes to register demux.
REQ-016 SHALL have port mem_rdAddr  output  ADDR_WIDTH  read address to register demux.
REQ-017 SHALL have port mem_rdStrobe  output  1  read strobe to register demux.
REQ-018 SHALL have port mem_rddout  input  DATA_WIDTH  read data from register demux.
REQ-019 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-020 SHALL have port grant_id  output  1  index of requester owning the current transaction.

Function
REQ-021 SHALL implement FSM states IDLE, WR, RD, RDWAIT, ACK.
REQ-022 IDLE: any req bit set -> select winner, latch its we/addr/wdata/wstrb and grant_id; next state WR if we, else RD.
REQ-023 Arbitration SHALL be round-robin: with both req high, winner is the requester not granted last; a single requester always wins.
REQ-024 WR (one cycle): mem_wrAddr/mem_wrdin = latched values, mem_wrByteStrobe = latched wstrb; -> ACK.
REQ-025 wstrb = 0 SHALL still complete: mem_wrByteStrobe stays 0, ack still pulses.
REQ-026 RD (one cycle): mem_rdAddr = latched addr, mem_rdStrobe = 1; load 3-bit counter with RD_LATENCY; -> RDWAIT.
REQ-027 RDWAIT: decrement counter each cycle; in the cycle counter reaches 1, capture mem_rddout into rdata[grant_id]; -> ACK.
REQ-028 ACK (one cycle): ack[grant_id] = 1, rdata[grant_id] valid; record grant_id as last-granted; -> IDLE.
REQ-029 Latency from req sampled in IDLE at cycle T: write strobe T+1, ack T+2; read strobe T+1, capture T+1+RD_LATENCY, ack T+2+RD_LATENCY.
REQ-030 mem_wrByteStrobe and mem_rdStrobe SHALL be 0 outside WR and RD respectively; addresses/wdata hold last value.
REQ-031 Requester inputs SHALL be ignored after latching; req dropped mid-transaction SHALL NOT abort it; ack still pulses.
REQ-032 req still high in the ACK cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-033 rdata[i] SHALL hold its value until the next read completed for requester i; writes SHALL NOT alter rdata.
REQ-034 Only one transaction SHALL be outstanding; a pending requester SHALL be granted after at most one other transaction.

Reset
REQ-035 S_AXI_ARESETN low at a clock edge SHALL force IDLE, ack=0, rdata=0, all mem_* outputs=0, busy=0, grant_id=0, counter=0, last-granted=1 (requester 0 wins first tie).
REQ-036 Reset asserted mid-transaction SHALL abort it with no strobe or ack issued afterwards.

Verification
REQ-037 Requester 0 write addr=5, wdata=0xDEADBEEF, wstrb=0xF -> WR cycle at T+1 with mem_wrAddr=5, mem_wrByteStrobe=0xF; ack[0] at T+2.
REQ-038 Requester 1 read addr=3, RD_LATENCY=2, mem_rddout=0x12345678 at T+3 -> mem_rdStrobe at T+1, ack[1] at T+4, rdata[1]=0x12345678.
REQ-039 Both req held high after reset, 4 writes -> grants 0,1,0,1; no requester waits more than one transaction.
REQ-040 Write with wstrb=0 -> mem_wrByteStrobe stays 0 all cycles, ack pulses at T+2.
REQ-041 Reset asserted in RDWAIT -> next cycle all outputs 0, no ack; following req from both -> requester 0 granted first.
